// File: rtl/bmc_spi_resp_pkg.sv
// Shared constants, frame-state encoding and small decode helpers for the
// BMC-side SPI egress responder.
package bmc_spi_resp_pkg;

    localparam logic [7:0]  CMD_WR        = 8'h02;
    localparam logic [7:0]  CMD_RD        = 8'h03;
    localparam logic [31:0] BAD_ADDR_DATA = 32'hBAD0_ADD5;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CMD    = 3'd1,
        ADDR   = 3'd2,
        WDATA  = 3'd3,
        RDATA  = 3'd4,
        DONE   = 3'd5,
        IGNORE = 3'd6
    } state_t;

    // Index of the final bit of the field collected in a given state.
    function automatic logic [5:0] last_bit_idx(input state_t s);
        case (s)
            CMD:          return 6'd7;
            ADDR:         return 6'd15;
            WDATA, RDATA: return 6'd31;
            default:      return 6'd0;
        endcase
    endfunction

    function automatic logic is_known_cmd(input logic [7:0] c);
        return (c == CMD_WR) || (c == CMD_RD);
    endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// Brings the asynchronous SPI pins into the clk domain and derives
// single-cycle edge strobes for sclk and csn.
module spi_pin_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic sclk,
    input  logic csn,
    input  logic mosi,
    output logic sclk_rise,
    output logic sclk_fall,
    output logic csn_s,
    output logic csn_fall,
    output logic csn_rise,
    output logic mosi_s
);

    logic       r_sclk_meta, r_sclk_sync, r_sclk_prev;
    logic       r_csn_meta,  r_csn_sync,  r_csn_prev;
    logic       r_mosi_meta, r_mosi_sync;
    logic [1:0] r_fill;
    logic       w_primed;

    // Edges are only trusted once every pipeline stage holds a post-reset
    // sample; otherwise a csn held low through reset looks like a fresh fall.
    assign w_primed = (r_fill == 2'd3);

    // Two-flop synchronisers plus one history flop for edge detection.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sclk_meta <= 1'b0;
            r_sclk_sync <= 1'b0;
            r_sclk_prev <= 1'b0;
            r_csn_meta  <= 1'b1;
            r_csn_sync  <= 1'b1;
            r_csn_prev  <= 1'b1;
            r_mosi_meta <= 1'b0;
            r_mosi_sync <= 1'b0;
            r_fill      <= 2'd0;
        end else begin
            r_sclk_meta <= sclk;
            r_sclk_sync <= r_sclk_meta;
            r_sclk_prev <= r_sclk_sync;
            r_csn_meta  <= csn;
            r_csn_sync  <= r_csn_meta;
            r_csn_prev  <= r_csn_sync;
            r_mosi_meta <= mosi;
            r_mosi_sync <= r_mosi_meta;
            if (!w_primed) r_fill <= r_fill + 2'd1;
        end
    end

    assign sclk_rise = w_primed &&  r_sclk_sync && !r_sclk_prev;
    assign sclk_fall = w_primed && !r_sclk_sync &&  r_sclk_prev;
    assign csn_fall  = w_primed && !r_csn_sync  &&  r_csn_prev;
    assign csn_rise  = w_primed &&  r_csn_sync  && !r_csn_prev;
    assign csn_s     = r_csn_sync;
    assign mosi_s    = r_mosi_sync;

endmodule

// File: rtl/bmc_spi_egress_responder.sv
// SPI mode-0 target terminating the PMCI egress link as the BMC end.
// Frames are CMD[7:0] ADDR[15:0] DATA[31:0]; writes land in a flop register
// file and raise a one-cycle event, reads stream the addressed word on miso.
// Handshake: wr_evt_valid is a pure one-cycle strobe with no ready; the
// consumer must sample wr_evt_addr/wr_evt_data in that cycle (they stay held
// until the next event, but nothing back-pressures the SPI master).
module bmc_spi_egress_responder
    import bmc_spi_resp_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int MIN_OVS = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        spi_sclk,
    input  logic        spi_csn,
    input  logic        spi_mosi,
    output logic        spi_miso,
    output logic        wr_evt_valid,
    output logic [15:0] wr_evt_addr,
    output logic [31:0] wr_evt_data,
    output logic [7:0]  abort_cnt,
    output logic [7:0]  err_cnt,
    output logic [2:0]  dbg_state
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic w_sclk_rise, w_sclk_fall, w_csn_s, w_csn_fall, w_csn_rise, w_mosi_s;

    spi_pin_sync u_pin_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .sclk      (spi_sclk),
        .csn       (spi_csn),
        .mosi      (spi_mosi),
        .sclk_rise (w_sclk_rise),
        .sclk_fall (w_sclk_fall),
        .csn_s     (w_csn_s),
        .csn_fall  (w_csn_fall),
        .csn_rise  (w_csn_rise),
        .mosi_s    (w_mosi_s)
    );

    state_t      r_state, w_state_nxt, w_after_rise;
    logic [5:0]  r_bitcnt;
    logic [31:0] r_shreg;
    logic        r_miso;
    logic        r_is_rd;
    logic [15:0] r_addr;
    logic        r_addr_ok;
    logic [31:0] r_regfile [DEPTH];
    logic        r_wr_evt_valid;
    logic [15:0] r_wr_evt_addr;
    logic [31:0] r_wr_evt_data;
    logic [7:0]  r_abort_cnt;
    logic [7:0]  r_err_cnt;

    logic        w_in_frame, w_bit_done;
    logic        w_cmd_done, w_addr_done, w_wdata_done;
    logic [7:0]  w_cmd;
    logic [15:0] w_addr_full;
    logic [31:0] w_wdata;
    logic        w_cmd_known, w_addr_in_range;
    logic [31:0] w_rd_word;
    logic        w_abort, w_err_inc;

    // Field assembly: the bit arriving this cycle completes the shifted value.
    assign w_cmd       = {r_shreg[6:0],  w_mosi_s};
    assign w_addr_full = {r_shreg[14:0], w_mosi_s};
    assign w_wdata     = {r_shreg[30:0], w_mosi_s};

    assign w_cmd_known     = is_known_cmd(w_cmd);
    assign w_addr_in_range = ((w_addr_full >> AW) == 16'd0);
    assign w_rd_word       = w_addr_in_range ? r_regfile[w_addr_full[AW-1:0]] : BAD_ADDR_DATA;

    assign w_in_frame   = (r_state == CMD) || (r_state == ADDR) ||
                          (r_state == WDATA) || (r_state == RDATA);
    assign w_bit_done   = w_sclk_rise && w_in_frame && (r_bitcnt == last_bit_idx(r_state));
    assign w_cmd_done   = w_bit_done && (r_state == CMD);
    assign w_addr_done  = w_bit_done && (r_state == ADDR);
    assign w_wdata_done = w_bit_done && (r_state == WDATA);

    assign w_err_inc = (w_cmd_done && !w_cmd_known) ||
                       (w_addr_done && r_is_rd && !w_addr_in_range) ||
                       (w_wdata_done && !r_addr_ok);

    // Frame state register.
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next state: apply the sclk rise first, then let csn_rise close the frame.
    always_comb begin
        w_after_rise = r_state;
        w_state_nxt  = r_state;
        w_abort      = 1'b0;
        case (r_state)
            IDLE:         if (w_csn_fall)   w_after_rise = CMD;
            CMD:          if (w_cmd_done)   w_after_rise = w_cmd_known ? ADDR : IGNORE;
            ADDR:         if (w_addr_done)  w_after_rise = r_is_rd ? RDATA : WDATA;
            WDATA, RDATA: if (w_bit_done)   w_after_rise = DONE;
            default:      w_after_rise = r_state;
        endcase
        w_state_nxt = w_after_rise;
        if (w_csn_rise) begin
            w_state_nxt = IDLE;
            w_abort     = (w_after_rise == CMD) || (w_after_rise == ADDR) ||
                          (w_after_rise == WDATA) || (w_after_rise == RDATA);
        end
    end

    // Bit counter restarts on every state change and while deselected.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_bitcnt <= 6'd0;
        end else if ((w_state_nxt != r_state) || w_csn_s) begin
            r_bitcnt <= 6'd0;
        end else if (w_sclk_rise && w_in_frame) begin
            r_bitcnt <= r_bitcnt + 6'd1;
        end
    end

    // Shift register: collects CMD/ADDR/WDATA on rises, serves read data on falls.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_shreg <= 32'd0;
        end else if (w_csn_s || (r_state == IDLE)) begin
            r_shreg <= 32'd0;
        end else if (w_addr_done && r_is_rd) begin
            r_shreg <= w_rd_word;
        end else if (w_sclk_rise && ((r_state == CMD) || (r_state == ADDR) || (r_state == WDATA))) begin
            r_shreg <= {r_shreg[30:0], w_mosi_s};
        end else if (w_sclk_fall && (r_state == RDATA)) begin
            r_shreg <= {r_shreg[30:0], 1'b0};
        end
    end

    // miso only carries data while a read is streaming; it is 0 everywhere else.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_miso <= 1'b0;
        end else if ((r_state == RDATA) && (w_state_nxt == RDATA)) begin
            if (w_sclk_fall) r_miso <= r_shreg[31];
        end else begin
            r_miso <= 1'b0;
        end
    end

    // Latch the decoded command direction and address for the data phase.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_is_rd   <= 1'b0;
            r_addr    <= 16'd0;
            r_addr_ok <= 1'b0;
        end else begin
            if (w_cmd_done) r_is_rd <= (w_cmd == CMD_RD);
            if (w_addr_done) begin
                r_addr    <= w_addr_full;
                r_addr_ok <= w_addr_in_range;
            end
        end
    end

    // Commit a completed in-range write and announce it for one cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_regfile[i] <= 32'd0;
            r_wr_evt_valid <= 1'b0;
            r_wr_evt_addr  <= 16'd0;
            r_wr_evt_data  <= 32'd0;
        end else begin
            r_wr_evt_valid <= 1'b0;
            if (w_wdata_done && r_addr_ok) begin
                r_regfile[r_addr[AW-1:0]] <= w_wdata;
                r_wr_evt_valid            <= 1'b1;
                r_wr_evt_addr             <= r_addr;
                r_wr_evt_data             <= w_wdata;
            end
        end
    end

    // Saturating abort and error counters; only rst_n clears them.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_abort_cnt <= 8'd0;
            r_err_cnt   <= 8'd0;
        end else begin
            if (w_abort && (r_abort_cnt != 8'hFF)) r_abort_cnt <= r_abort_cnt + 8'd1;
            if (w_err_inc && (r_err_cnt != 8'hFF)) r_err_cnt   <= r_err_cnt + 8'd1;
        end
    end

    assign spi_miso     = r_miso;
    assign wr_evt_valid = r_wr_evt_valid;
    assign wr_evt_addr  = r_wr_evt_addr;
    assign wr_evt_data  = r_wr_evt_data;
    assign abort_cnt    = r_abort_cnt;
    assign err_cnt      = r_err_cnt;
    assign dbg_state    = r_state;

`ifndef SYNTHESIS
    localparam logic [7:0] HALF_MIN = 8'(MIN_OVS / 2);
    logic [7:0] r_ph_cnt;

    // Measure each selected sclk phase in clk cycles; too short means the
    // oversampling ratio is below what the synchroniser path can follow.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ph_cnt <= 8'hFF;
        end else begin
            if (w_sclk_rise || w_sclk_fall)  r_ph_cnt <= 8'd1;
            else if (r_ph_cnt != 8'hFF)      r_ph_cnt <= r_ph_cnt + 8'd1;
            if ((w_sclk_rise || w_sclk_fall) && !w_csn_s) assert (r_ph_cnt >= HALF_MIN);
        end
    end
`endif

endmodule

// File: tb/tb_bmc_spi_egress_responder.sv
// Directed bench for the SPI egress responder: drives mode-0 frames at the
// minimum oversampling ratio and checks against a frame-level model.
module tb_bmc_spi_egress_responder;

    localparam int HALF  = 4;   // clk cycles per sclk phase (ratio 8)
    localparam int DEPTH = 16;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        spi_sclk, spi_csn, spi_mosi;
    logic        spi_miso;
    logic        wr_evt_valid;
    logic [15:0] wr_evt_addr;
    logic [31:0] wr_evt_data;
    logic [7:0]  abort_cnt, err_cnt;
    logic [2:0]  dbg_state;

    bmc_spi_egress_responder #(.DEPTH(DEPTH), .MIN_OVS(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .spi_sclk     (spi_sclk),
        .spi_csn      (spi_csn),
        .spi_mosi     (spi_mosi),
        .spi_miso     (spi_miso),
        .wr_evt_valid (wr_evt_valid),
        .wr_evt_addr  (wr_evt_addr),
        .wr_evt_data  (wr_evt_data),
        .abort_cnt    (abort_cnt),
        .err_cnt      (err_cnt),
        .dbg_state    (dbg_state)
    );

    // ---------------- scoreboard / model ----------------
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] m_reg [DEPTH];
    int          m_err, m_abort;
    logic [15:0] m_last_addr;
    logic [31:0] m_last_data;
    logic [47:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic int sat8(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_reg[i] = 32'd0;
        m_err = 0; m_abort = 0;
        m_last_addr = 16'd0; m_last_data = 32'd0;
        exp_q.delete();
    endtask

    // Frame-level effect of sending the first nbits of {cmd,addr,data}.
    task automatic model_predict(input logic [7:0] cmd, input logic [15:0] addr,
                                 input logic [31:0] data, input int nbits,
                                 output logic [31:0] exp_rd, output logic is_rd);
        exp_rd = 32'd0;
        is_rd  = 1'b0;
        if (nbits < 8) begin
            m_abort = sat8(m_abort + 1);
        end else if (cmd != 8'h02 && cmd != 8'h03) begin
            m_err = sat8(m_err + 1);
        end else if (nbits < 56) begin
            if (cmd == 8'h03 && nbits >= 24 && addr >= DEPTH) m_err = sat8(m_err + 1);
            m_abort = sat8(m_abort + 1);
        end else if (cmd == 8'h03) begin
            is_rd = 1'b1;
            if (addr < DEPTH) exp_rd = m_reg[addr];
            else begin exp_rd = 32'hBAD0ADD5; m_err = sat8(m_err + 1); end
        end else if (addr < DEPTH) begin
            m_reg[addr] = data;
            exp_q.push_back({addr, data});
            m_last_addr = addr;
            m_last_data = data;
        end else begin
            m_err = sat8(m_err + 1);
        end
    endtask

    // ---------------- compare process ----------------
    logic prev_valid;
    int   csn_hi_cnt;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid = 1'b0;
            csn_hi_cnt = 0;
        end else begin
            if (wr_evt_valid) begin
                logic [47:0] e;
                check("evt_pulse_width", prev_valid, 1'b0);
                check("evt_expected", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("evt_addr", wr_evt_addr, e[47:32]);
                    check("evt_data", wr_evt_data, e[31:0]);
                end
            end
            csn_hi_cnt = spi_csn ? csn_hi_cnt + 1 : 0;
            if (csn_hi_cnt >= HALF) check("miso_idle", spi_miso, 1'b0);
            prev_valid = wr_evt_valid;
        end
    end

    // ---------------- driver ----------------
    task automatic run_frame(input logic [7:0] cmd, input logic [15:0] addr,
                             input logic [31:0] data, input int nbits,
                             input bit sim_end, input bit keep_csn,
                             output logic [55:0] rx);
        logic [55:0] vec;
        vec = {cmd, addr, data};
        rx  = 56'd0;
        spi_csn = 1'b0;
        repeat (HALF) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = vec[55-i];
            repeat (HALF) @(negedge clk);
            rx[55-i] = spi_miso;
            spi_sclk = 1'b1;
            if (sim_end && i == nbits - 1) spi_csn = 1'b1;
            repeat (HALF) @(negedge clk);
            spi_sclk = 1'b0;
        end
        spi_mosi = 1'b0;
        if (!keep_csn) begin
            repeat (HALF) @(negedge clk);
            spi_csn = 1'b1;
            repeat (4 * HALF) @(negedge clk);   // two sclk periods deselected
        end
    endtask

    task automatic check_status(input string name);
        check({name, "_abort_cnt"}, abort_cnt, m_abort);
        check({name, "_err_cnt"}, err_cnt, m_err);
        check({name, "_evt_addr_hold"}, wr_evt_addr, m_last_addr);
        check({name, "_evt_data_hold"}, wr_evt_data, m_last_data);
        check({name, "_evt_drained"}, exp_q.size(), 0);
    endtask

    task automatic xact(input string name, input logic [7:0] cmd, input logic [15:0] addr,
                        input logic [31:0] data, input int nbits, input bit sim_end,
                        output logic [55:0] rx);
        logic [31:0] exp_rd;
        logic        is_rd;
        model_predict(cmd, addr, data, nbits, exp_rd, is_rd);
        run_frame(cmd, addr, data, nbits, sim_end, 1'b0, rx);
        if (is_rd) begin
            check({name, "_miso_hdr"}, rx[55:32], 24'd0);
            check({name, "_miso_data"}, rx[31:0], exp_rd);
        end else begin
            check({name, "_miso_zero"}, rx, 56'd0);
        end
        check_status(name);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [55:0] rx;
        rst_n = 1'b0; spi_sclk = 1'b0; spi_csn = 1'b1; spi_mosi = 1'b0;
        model_reset();
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_miso", spi_miso, 1'b0);
        check("rst_evt_valid", wr_evt_valid, 1'b0);
        check("rst_state_idle", dbg_state, 3'd0);
        check_status("rst");

        xact("wr4", 8'h02, 16'h0004, 32'hCAFEF00D, 56, 1'b0, rx);
        check("wr4_evt_addr_literal", wr_evt_addr, 16'h0004);
        check("wr4_evt_data_literal", wr_evt_data, 32'hCAFEF00D);

        xact("rd4", 8'h03, 16'h0004, 32'h0, 56, 1'b0, rx);
        check("rd4_literal", rx[31:0], 32'hCAFEF00D);

        xact("rd_bad", 8'h03, 16'h0010, 32'h0, 56, 1'b0, rx);
        check("rd_bad_literal", rx[31:0], 32'hBAD0ADD5);
        check("rd_bad_err_literal", err_cnt, 8'd1);

        xact("wr5_abort", 8'h02, 16'h0005, 32'h12345678, 20, 1'b0, rx);
        check("abort_literal", abort_cnt, 8'd1);
        xact("rd5_after_abort", 8'h03, 16'h0005, 32'h0, 56, 1'b0, rx);
        xact("wr5", 8'h02, 16'h0005, 32'h12345678, 56, 1'b0, rx);
        xact("rd5", 8'h03, 16'h0005, 32'h0, 56, 1'b0, rx);

        xact("unknown_cmd", 8'h7F, 16'h0005, 32'hFFFFFFFF, 56, 1'b0, rx);
        xact("wr_oob", 8'h02, 16'h0020, 32'h55AA55AA, 56, 1'b0, rx);
        xact("rd4_after_oob", 8'h03, 16'h0004, 32'h0, 56, 1'b0, rx);

        // Last rise and csn release land together: frame completes, no abort.
        xact("wr7_same_cycle", 8'h02, 16'h0007, 32'hA5A55A5A, 56, 1'b1, rx);
        xact("rd7", 8'h03, 16'h0007, 32'h0, 56, 1'b0, rx);

        // Reset in the middle of the write data phase (10 data bits sent).
        run_frame(8'h02, 16'h0003, 32'h11112222, 34, 1'b0, 1'b1, rx);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        repeat (4) @(negedge clk);
        check("midrst_miso", spi_miso, 1'b0);
        check("midrst_state_idle", dbg_state, 3'd0);
        check_status("midrst");
        spi_csn = 1'b1;
        repeat (4 * HALF) @(negedge clk);
        xact("rd4_after_rst", 8'h03, 16'h0004, 32'h0, 56, 1'b0, rx);
        xact("rd3_after_rst", 8'h03, 16'h0003, 32'h0, 56, 1'b0, rx);

        // Back-to-back writes with minimum deselect gap, then read both.
        xact("wr0", 8'h02, 16'h0000, 32'hDEADBEEF, 56, 1'b0, rx);
        xact("wr1", 8'h02, 16'h0001, 32'h0BADF00D, 56, 1'b0, rx);
        xact("rd0", 8'h03, 16'h0000, 32'h0, 56, 1'b0, rx);
        check("rd0_literal", rx[31:0], 32'hDEADBEEF);
        xact("rd1", 8'h03, 16'h0001, 32'h0, 56, 1'b0, rx);
        check("rd1_literal", rx[31:0], 32'h0BADF00D);

        check("final_evt_queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Hard stop in case the run never reaches the summary.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected summary");
        $fatal(1, "timeout");
    end

endmodule
